// File: rtl/snake_tick_pkg.sv
// Shared types, constants and the period helper for the snake game-tick generator.
package snake_tick_pkg;

    // Width of the wrapping game-tick counter.
    localparam int TICK_CNT_W = 16;

    // Tick FSM: free running, frozen, or emitting one single-step tick.
    typedef enum logic [1:0] {
        RUN,
        PAUSED,
        STEP
    } tick_state_t;

    // Tick period for a speed level: base minus level*step, floored at min_div.
    // The product is formed in 64 bits, so large levels saturate instead of wrapping.
    function automatic int unsigned div_for_level(
        input int unsigned base_div,
        input int unsigned step_div,
        input int unsigned min_div,
        input int unsigned level
    );
        logic [63:0]  reduction;
        int unsigned  result;
        reduction = 64'(level) * 64'(step_div);
        if (base_div <= min_div || reduction >= 64'(base_div - min_div))
            result = min_div;
        else
            result = base_div - 32'(reduction);
        return result;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter: counts 0..last, returns to 0 after last, with a wrap strobe.
module mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    // Wrap fires on the enabled cycle that moves the count from last back to 0.
    // A count above last (only possible if last shrinks) also wraps immediately.
    assign wrap = en && !clr && (cnt >= last);

    // Count register: clear dominates enable.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt >= last) ? '0 : cnt + WIDTH'(1);
    end

endmodule

// File: rtl/snake_tick_gen.sv
// Game-tick generator: speed-levelled update strobe with pause/single-step,
// a wrapping tick counter and a free-running blink square wave.
module snake_tick_gen
    import snake_tick_pkg::*;
#(
    parameter int unsigned BASE_DIV  = 4_000_000,
    parameter int unsigned STEP_DIV  = 250_000,
    parameter int unsigned MIN_DIV   = 1_000_000,
    parameter int          LEVEL_W   = 4,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LEVEL_W-1:0]    level_in,
    input  logic                  level_load,
    input  logic                  pause,
    input  logic                  step,
    output logic                  update_clk,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [LEVEL_W-1:0]    level_o,
    output logic                  paused_o,
    output logic                  blink
);

    localparam int unsigned MAX_DIV = (BASE_DIV > BLINK_DIV) ? BASE_DIV : BLINK_DIV;
    localparam int          CNT_W   = $clog2(MAX_DIV);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    tick_state_t        state;
    logic [LEVEL_W-1:0] pending_level;
    logic [LEVEL_W-1:0] next_level;
    int unsigned        game_div;
    logic [CNT_W-1:0]   game_last;
    logic [CNT_W-1:0]   game_cnt;
    logic [CNT_W-1:0]   blink_cnt_unused;
    logic               game_at_last;
    logic               game_en;
    logic               game_clr;
    logic               game_wrap;
    logic               blink_wrap;
    logic               fire;

    // Period of the active level; it only changes at a wrap or a step, so a
    // running period always completes with the modulus it started with.
    assign game_div     = div_for_level(BASE_DIV, STEP_DIV, MIN_DIV, 32'(level_o));
    assign game_last    = CNT_W'(game_div - 1);
    assign game_at_last = (game_cnt >= game_last);

    // In RUN the count advances unless pause is requested; a wrap that lands on
    // the same cycle as pause still completes so that tick is not lost.
    assign game_en  = (state == RUN) && (!pause || game_at_last);
    assign game_clr = (state == STEP);
    assign fire     = game_wrap || (state == STEP);

    // A load in the same cycle as a wrap/step governs the following period.
    assign next_level = level_load ? level_in : pending_level;

    mod_counter #(
        .WIDTH (CNT_W)
    ) u_game_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (game_en),
        .clr   (game_clr),
        .last  (game_last),
        .cnt   (game_cnt),
        .wrap  (game_wrap)
    );

    mod_counter #(
        .WIDTH (CNT_W)
    ) u_blink_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .last  (BLINK_LAST),
        .cnt   (blink_cnt_unused),
        .wrap  (blink_wrap)
    );

    // Tick FSM with its registered outputs, tick counter and level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            update_clk    <= 1'b0;
            tick_count    <= '0;
            level_o       <= '0;
            pending_level <= '0;
            paused_o      <= 1'b0;
        end else begin
            update_clk <= fire;
            paused_o   <= (state != RUN);

            if (fire) begin
                tick_count <= tick_count + TICK_CNT_W'(1);
                level_o    <= next_level;
            end

            if (level_load)
                pending_level <= level_in;

            case (state)
                RUN: begin
                    if (pause)
                        state <= PAUSED;
                end
                PAUSED: begin
                    if (step)
                        state <= STEP;
                    else if (!pause)
                        state <= RUN;
                end
                STEP: begin
                    state <= pause ? PAUSED : RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Blink square wave: toggles once per blink-counter wrap, whatever the FSM does.
    always_ff @(posedge clk) begin
        if (reset)
            blink <= 1'b0;
        else if (blink_wrap)
            blink <= ~blink;
    end

endmodule
